// File: rtl/tc_bitmem_pkg.sv
// Shared types and the round-robin pick function for the bit-memory arbiter.
// Used by tc_rr_pick and tc_bitmem_arbiter.
package tc_bitmem_pkg;

  localparam int MAX_NREQ = 8;
  localparam int MAX_IW   = $clog2(MAX_NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } pick_t;

  // Returns the first set bit at or after ptr, wrapping. The mask is zero above
  // the real requester count, so wrapping modulo MAX_NREQ gives the same winner
  // as wrapping modulo NREQ.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req_mask,
                                    input logic [MAX_IW-1:0]   ptr);
    pick_t             res;
    logic [MAX_IW-1:0] pos;
    res = '0;
    // Scan from the farthest slot back toward ptr so the nearest candidate wins.
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      pos = ptr + MAX_IW'(k);
      if (req_mask[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Combinational round-robin priority picker for NREQ requesters (2..8).
// Widens the request mask and pointer to the package width and calls rr_pick.
module tc_rr_pick
  import tc_bitmem_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_mask,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [MAX_NREQ-1:0] mask_ext;
  logic [MAX_IW-1:0]   ptr_ext;
  pick_t               res;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mask_ext             = '0;
    mask_ext[NREQ-1:0]   = req_mask;
    ptr_ext              = '0;
    ptr_ext[IW-1:0]      = ptr;
    res                  = rr_pick(mask_ext, ptr_ext);
    found                = res.found;
    idx                  = res.idx[IW-1:0];
  end

endmodule

// File: rtl/tc_bitmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one bank of 1-bit cells among NREQ requesters.
// Optional macro TC_BITMEM_ARB_LOCK_EN adds a per-requester lock for back-to-back grants.
module tc_bitmem_arbiter
  import tc_bitmem_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ-1:0]    wdata,
`ifdef TC_BITMEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic               rdata,
  output logic               bank_save,
  output logic [AW-1:0]      bank_addr,
  output logic               bank_in,
  input  logic               bank_out
);

  localparam int          IW      = $clog2(NREQ);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   win_q, ptr_q, ptr_next, pick_idx;
  logic            pick_found, locked;
  logic [NREQ-1:0] gnt_vec, cand;
  logic [AW-1:0]   sel_addr;
  logic            sel_oob;

  logic            iss_read, iss_oob;
  logic [AW-1:0]   bank_addr_q;
  logic            bank_in_q, bank_save_q;

  logic            rv_valid, rv_oob;
  logic [IW-1:0]   rv_idx;

  always_comb begin
    gnt_vec = '0;
    if (state_q == ISSUE) gnt_vec[win_q] = 1'b1;
  end

  // The requester served this cycle still shows req, so it is masked out
  // unless it holds the lock on its own grant.
`ifdef TC_BITMEM_ARB_LOCK_EN
  assign locked = (state_q == ISSUE) && lock[win_q] && req[win_q];
`else
  assign locked = 1'b0;
`endif
  assign cand = locked ? gnt_vec : (req & ~gnt_vec);

  tc_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_mask (cand),
    .ptr      (ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign sel_addr = addr[int'(pick_idx)*AW +: AW];
  assign sel_oob  = {1'b0, sel_addr} >= DEPTH_V;
  assign ptr_next = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);

  always_comb begin
    state_d = IDLE;
    if (pick_found) state_d = ISSUE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      ptr_q       <= '0;
      bank_addr_q <= '0;
      bank_in_q   <= 1'b0;
      bank_save_q <= 1'b0;
      iss_read    <= 1'b0;
      iss_oob     <= 1'b0;
      rv_valid    <= 1'b0;
      rv_idx      <= '0;
      rv_oob      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rv_valid    <= (state_q == ISSUE) && iss_read;
      rv_idx      <= win_q;
      rv_oob      <= iss_oob;
      bank_save_q <= 1'b0;
      if (pick_found) begin
        win_q       <= pick_idx;
        bank_addr_q <= sel_addr;
        bank_in_q   <= wdata[pick_idx];
        bank_save_q <= we[pick_idx] & ~sel_oob;
        iss_read    <= ~we[pick_idx];
        iss_oob     <= sel_oob;
        if (!locked) ptr_q <= ptr_next;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (rv_valid) rvalid[rv_idx] = 1'b1;
  end

  // bank_out is already registered inside the bank, so data is passed straight through.
  assign rdata     = rv_valid & ~rv_oob & bank_out;
  assign gnt       = gnt_vec;
  assign bank_save = bank_save_q;
  assign bank_addr = bank_addr_q;
  assign bank_in   = bank_in_q;

endmodule

// File: tb/tb_tc_bitmem_arbiter.sv
// Self-checking bench for tc_bitmem_arbiter with a bit-cell bank model and a
// cycle-level reference model of the arbitration and read-return rules.
module tb_tc_bitmem_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 6;   // leaves addresses 6 and 7 out of range
  localparam int AW    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, we, wdata;
  logic [NREQ*AW-1:0] addr;
`ifdef TC_BITMEM_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt, rvalid;
  logic               rdata, bank_save, bank_in;
  logic               bank_out = 1'b0;
  logic [AW-1:0]      bank_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic bank_mem [0:7];
  logic ref_mem  [0:7];

  always #5 clk = ~clk;

  tc_bitmem_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef TC_BITMEM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bank_save (bank_save),
    .bank_addr (bank_addr),
    .bank_in   (bank_in),
    .bank_out  (bank_out)
  );

  // Bank: commits on the falling edge of the save cycle, read data one cycle after the address.
  always @(negedge clk) if (bank_save === 1'b1) bank_mem[bank_addr] = bank_in;
  always @(posedge clk) bank_out <= bank_mem[bank_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_ptr, m_last, m_win, m_a;
  bit              m_last_rd, m_last_data, m_nd, m_lk;
  logic [NREQ-1:0] m_g, m_rv;

  function automatic bit is_cand(input int i, input int last, input bit lk);
    if (lk) return (i == last);
    return (req[i] === 1'b1) && (i != last);
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_ptr  = 0;
      m_last = -1;
      check("rst_gnt", gnt, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bank_save", bank_save, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bank_addr", bank_addr, 0);
      check("rst_bank_in", bank_in, 0);
    end else begin
      m_lk = 1'b0;
`ifdef TC_BITMEM_ARB_LOCK_EN
      if (m_last >= 0) m_lk = lock[m_last] && req[m_last];
`endif
      m_win = -1;
      for (int k = 0; k < NREQ; k++)
        if (m_win < 0 && is_cand((m_ptr + k) % NREQ, m_last, m_lk)) m_win = (m_ptr + k) % NREQ;
      m_g  = '0;
      m_nd = 1'b0;
      if (m_win >= 0) m_g[m_win] = 1'b1;
      check("gnt", gnt, m_g);
      if (m_win >= 0) begin
        m_a = int'(addr[m_win*AW +: AW]);
        check("bank_save", bank_save, (we[m_win] && m_a < DEPTH) ? 1 : 0);
        check("bank_addr", bank_addr, m_a);
        check("bank_in", bank_in, wdata[m_win]);
        if (!we[m_win] && m_a < DEPTH) m_nd = ref_mem[m_a];
        if (we[m_win] && m_a < DEPTH) ref_mem[m_a] = wdata[m_win];
        if (!m_lk) m_ptr = (m_win + 1) % NREQ;
      end else begin
        check("bank_save_idle", bank_save, 0);
      end
      m_rv = '0;
      if (m_last >= 0 && m_last_rd) m_rv[m_last] = 1'b1;
      check("rvalid", rvalid, m_rv);
      if (m_last >= 0 && m_last_rd) check("rdata", rdata, m_last_data);
      m_last      = m_win;
      m_last_rd   = (m_win >= 0) && !we[m_win];
      m_last_data = m_nd;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
`ifdef TC_BITMEM_ARB_LOCK_EN
    lock  = '0;
`endif
  endtask

  task automatic set_req(input int i, input bit w, input int a, input bit d);
    req[i]            = 1'b1;
    we[i]             = w;
    addr[i*AW +: AW]  = a[AW-1:0];
    wdata[i]          = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] rr_order [0:4];

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) begin
      bank_mem[i] = 1'b0;
      ref_mem[i]  = 1'b0;
    end
    bank_mem[3] = 1'b1; ref_mem[3] = 1'b1;
    bank_mem[6] = 1'b1; ref_mem[6] = 1'b1;
    bank_mem[7] = 1'b1; ref_mem[7] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single read of cell 3
    @(negedge clk); set_req(0, 1'b0, 3, 1'b0);
    tick(); check("t1_gnt", gnt, 4'b0001); check("t1_bank_addr", bank_addr, 3);
    @(negedge clk); idle();
    tick(); check("t1_rvalid", rvalid, 4'b0001); check("t1_rdata", rdata, 1);

    // Write then read by the same requester
    @(negedge clk); set_req(1, 1'b1, 5, 1'b1);
    tick(); check("t2_gnt_w", gnt, 4'b0010); check("t2_save", bank_save, 1);
    @(negedge clk); set_req(1, 1'b0, 5, 1'b0);
    tick(); check("t2_no_rvalid", rvalid, 0); check("t2_gap", gnt, 0);
    tick(); check("t2_gnt_r", gnt, 4'b0010); check("t2_save_r", bank_save, 0);
    @(negedge clk); idle();
    tick(); check("t2_rvalid", rvalid, 4'b0010); check("t2_rdata", rdata, 1);

    // Write in K, read of the same cell in K+1 by another requester
    apply_reset();
    @(negedge clk); set_req(0, 1'b1, 2, 1'b1); set_req(1, 1'b0, 2, 1'b0);
    tick(); check("t3_gnt_w", gnt, 4'b0001); check("t3_save", bank_save, 1);
    @(negedge clk); req[0] = 1'b0;
    tick(); check("t3_gnt_r", gnt, 4'b0010);
    @(negedge clk); idle();
    tick(); check("t3_rvalid", rvalid, 4'b0010); check("t3_rdata", rdata, 1);

    // Full contention from pointer 0
    apply_reset();
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(); check($sformatf("t4_rr%0d", k), gnt, rr_order[k]);
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);

    // Single requester held: grant every other cycle
    set_req(2, 1'b0, 1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(); check($sformatf("t5_c%0d", k), gnt, (k % 2 == 1) ? 4'b0100 : 4'b0000);
      if (k == 5) begin
        @(negedge clk); idle();
      end
    end

    // Reset while a read is in flight
    repeat (2) @(negedge clk);
    set_req(0, 1'b0, 3, 1'b0);
    tick(); check("t6_gnt", gnt, 4'b0001);
    @(negedge clk); rst = 1'b1; idle();
    tick(); check("t6_drop_a", rvalid, 0);
    tick(); check("t6_drop_b", rvalid, 0);
    @(negedge clk); rst = 1'b0; set_req(0, 1'b0, 3, 1'b0); set_req(1, 1'b0, 4, 1'b0);
    tick(); check("t6_ptr0", gnt, 4'b0001);
    @(negedge clk); req[0] = 1'b0;
    tick(); check("t6_next", gnt, 4'b0010); check("t6_rdata", rdata, 1);
    @(negedge clk); idle();
    tick(); check("t6_rvalid1", rvalid, 4'b0010);

    // Out-of-range address: grant still pulses, no save, read returns 0
    repeat (2) @(negedge clk);
    set_req(3, 1'b1, 7, 1'b0);
    tick(); check("t7_gnt_w", gnt, 4'b1000); check("t7_no_save", bank_save, 0);
    @(negedge clk); set_req(3, 1'b0, 6, 1'b0);
    tick(); check("t7_no_rvalid", rvalid, 0);
    tick(); check("t7_gnt_r", gnt, 4'b1000);
    @(negedge clk); idle();
    tick(); check("t7_rvalid", rvalid, 4'b1000); check("t7_rdata", rdata, 0);
    check("t7_cell7_kept", bank_mem[7], 1);

    // Withdrawn request is never granted
    apply_reset();
    @(negedge clk); set_req(0, 1'b0, 0, 1'b0); set_req(1, 1'b0, 1, 1'b0);
    tick(); check("t8_gnt", gnt, 4'b0001);
    @(negedge clk); idle();
    tick(); check("t8_withdrawn_a", gnt, 0);
    tick(); check("t8_withdrawn_b", gnt, 0);

`ifdef TC_BITMEM_ARB_LOCK_EN
    // Lock: back-to-back grants to the locked requester, then release
    apply_reset();
    @(negedge clk); set_req(0, 1'b0, 3, 1'b0); set_req(1, 1'b0, 4, 1'b0); lock[0] = 1'b1;
    tick(); check("t9_c1", gnt, 4'b0001);
    tick(); check("t9_c2", gnt, 4'b0001);
    tick(); check("t9_c3", gnt, 4'b0001);
    @(negedge clk); lock[0] = 1'b0;
    tick(); check("t9_release", gnt, 4'b0010);
    @(negedge clk); idle();
    tick(); check("t9_idle", gnt, 0);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tc_bitmem_arbiter.md
Name: tc_bitmem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of single-bit memory cells among NREQ requesters.
- Each requester presents a read or write with a req/gnt handshake. The arbiter issues one bank command per cycle and routes read data back to the winner.
- Sits between the Turing-Complete-style CPU units (register bits, flag cells) and a bit-memory bank built from TC bit-memory cells.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 8, number of 1-bit cells in the bank.
- AW, $clog2(DEPTH), address width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request, held until gnt.
- we  in  NREQ  per-requester write (1) / read (0), held with req.
- addr  in  NREQ*AW  packed addresses; slice i belongs to requester i.
- wdata  in  NREQ  per-requester write bit.
- gnt  out  NREQ  one-hot grant pulse, at most one bit set.
- rvalid  out  NREQ  one-hot read-data-valid pulse.
- rdata  out  1  read data, meaningful only while rvalid is nonzero.
- bank_save  out  1  write strobe to bank; the bank commits on the falling edge of the same cycle.
- bank_addr  out  AW  bank cell select.
- bank_in  out  1  bank write data.
- bank_out  in  1  bank read data; valid one cycle after bank_addr is presented.

Behaviour:
- Reset (async assert, sync deassert use):
  - gnt, rvalid, bank_save = 0.
  - rdata, bank_addr, bank_in = 0.
  - Round-robin pointer = 0.
  - FSM = IDLE.
  - An in-flight read is dropped: no rvalid is issued for it after reset.
- Arbitration (cycle N):
  - Candidates are req bits, minus the requester granted in cycle N (its req still reflects the request just served).
  - The winner is the first candidate at or after the pointer, wrapping modulo NREQ.
  - The pointer moves to winner+1 mod NREQ, and only when a grant occurs.
- Issue (cycle N+1):
  - gnt[winner]=1 for exactly one cycle.
  - bank_addr = addr slice of winner, bank_in = wdata, bank_save = we of winner.
  - All are registered from values sampled in N.
  - Requester may change req/we/addr/wdata from N+2.
- Read return:
  - rvalid[winner]=1 and rdata=bank_out in cycle N+2. Fixed latency: 2 cycles from req sample to data.
  - Write: no rvalid.
- Throughput:
  - One grant per cycle when different requesters compete.
  - A single requester holding req gets a grant every other cycle.
- FSM states:
  - IDLE: no grant this cycle. Any candidate → ISSUE.
  - ISSUE: gnt asserted. Candidate present → ISSUE; none → IDLE.
  - A read-return stage runs in parallel as a 1-deep pipeline register (valid bit plus winner index).
- Read after write:
  - Write issued in cycle K, read of the same address issued in K+1 → rdata returns the new bit, because the bank commits on the falling edge of K.
- Read and write to the same address are never issued in one cycle (single port).
- addr ≥ DEPTH: bank_save is forced to 0 for that grant; reads return 0. The grant still pulses, so the requester is not hung.
- req dropped before grant: the request is withdrawn. No gnt is required, and the arbiter must not grant a requester whose req was 0 when sampled.

Optional Feature:
- Macro: TC_BITMEM_ARB_LOCK_EN.
- With macro defined:
  - Extra input lock (NREQ bits).
  - If the granted requester has lock=1 in its grant cycle, the next arbitration considers only that requester. Its back-to-back requests get consecutive-cycle grants, enabling read-modify-write.
  - The lock releases when lock drops or req drops.
  - Pointer advancement is suppressed while locked.
- Without macro:
  - No lock port; behaviour exactly as above.

Decomposition:
- Package tc_bitmem_pkg holds:
  - MAX_NREQ = 8.
  - The typedef for the FSM state enum {IDLE, ISSUE}.
  - A function rr_pick(req_mask, ptr) returning the winner index and a found flag.
- One natural sub-module: tc_rr_pick, the combinational round-robin priority picker with parameter NREQ.
- FSM, issue registers and read-return pipeline stay in the top module.

Test Plan:
- Single read: preload cell 3=1; req[0]=1, we=0, addr=3 at cycle 0 → gnt[0] at cycle 1, rvalid[0]=1 and rdata=1 at cycle 2.
- Write then read: req[1] write addr=5 wdata=1, then read addr=5 → read returns rdata=1; no rvalid on the write.
- Full contention: req=4'b1111 held, pointer 0 → gnt order 0,1,2,3,0 on consecutive cycles, one-hot every cycle.
- Single requester held: req=4'b0100 for 6 cycles → gnt[2] on cycles 1,3,5 only.
- Reset mid-read: assert rst in the cycle after gnt[0] for a read → rvalid stays 0; after release, pointer=0 and req=4'b0011 grants requester 0 first.
- Lock (TC_BITMEM_ARB_LOCK_EN): req=4'b0011, lock[0]=1 → gnt[0] on cycles 1,2,3 while locked; lock[0]=0 → next grant goes to requester 1.
